// File: rtl/aes_pkg.sv
// Shared AES datapath definitions for the forward and inverse column engines:
// field polynomial, state/column geometry, column byte layout and engine FSM states.
package aes_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned STATE_W  = 128;
  localparam int unsigned NUM_COLS = STATE_W / COL_W;

  localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

  // Element [NUM_COLS-1] is column 0, so the packed view matches the 128-bit bus layout.
  typedef logic [NUM_COLS-1:0][COL_W-1:0] state_t;

  // One column, row 0 byte in the MSB.
  typedef struct packed {
    logic [BYTE_W-1:0] b0;
    logic [BYTE_W-1:0] b1;
    logic [BYTE_W-1:0] b2;
    logic [BYTE_W-1:0] b3;
  } column_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] v);
    return {v[BYTE_W-2:0], 1'b0} ^ (v[BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Forward AES MixColumns of a single 32-bit column (purely combinational).
module mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_c
);

  column_t a;
  column_t b;

  assign a = column_t'(col_in);

  // 3*v is expressed as xtime(v) ^ v.
  always_comb begin
    b    = '0;
    b.b0 = xtime(a.b0) ^ xtime(a.b1) ^ a.b1 ^ a.b2 ^ a.b3;
    b.b1 = a.b0 ^ xtime(a.b1) ^ xtime(a.b2) ^ a.b2 ^ a.b3;
    b.b2 = a.b0 ^ a.b1 ^ xtime(a.b2) ^ xtime(a.b3) ^ a.b3;
    b.b3 = xtime(a.b0) ^ a.b0 ^ a.b1 ^ a.b2 ^ xtime(a.b3);
  end

  assign col_c = COL_W'(b);

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative forward AES MixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock,
// with valid/ready handshakes on both sides and a sideband tag carried alongside.
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter int unsigned TAG_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_state,
  input  logic               in_bypass,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_state,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned CNT_W = $clog2(NUM_COLS);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COLS - COLS_PER_CYCLE);
  localparam logic [CNT_W-1:0] COL_TOP  = CNT_W'(NUM_COLS - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            work_q, work_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              valid_q, valid_d;

  state_t            src_c;
  state_t            mixed_c;
  logic              accept_c;
  logic              last_c;
  logic [CNT_W-1:0]  grp_col [COLS_PER_CYCLE];
  logic [COL_W-1:0]  grp_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]  grp_out [COLS_PER_CYCLE];

  // In DONE the slot frees up the same cycle the result is taken.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_c = in_valid && in_ready;
  assign last_c   = (cnt_q == CNT_LAST);

  // The first group is mixed straight from in_state on the accept edge, so a mixed
  // result takes 4/COLS_PER_CYCLE edges and back-to-back throughput matches.
  assign src_c = (state_q == ST_BUSY) ? work_q : state_t'(in_state);

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign grp_col[g] = cnt_q + CNT_W'(g);
    assign grp_in[g]  = src_c[COL_TOP - grp_col[g]];

    mix_column_word u_mix (
      .col_in (grp_in[g]),
      .col_c  (grp_out[g])
    );
  end

  // Source state with the current column group replaced by its mixed value.
  always_comb begin
    mixed_c = src_c;
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      mixed_c[COL_TOP - grp_col[g]] = grp_out[g];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    tag_d   = tag_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
        if (accept_c) begin
          tag_d = in_tag;
          cnt_d = '0;
          if (in_bypass) begin
            work_d  = state_t'(in_state);
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            work_d = mixed_c;
            if (last_c) begin
              state_d = ST_DONE;
              valid_d = 1'b1;
            end else begin
              state_d = ST_BUSY;
              cnt_d   = CNT_STEP;
            end
          end
        end
      end

      ST_BUSY: begin
        work_d = mixed_c;
        if (last_c) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_state = STATE_W'(work_q);
  assign out_tag   = tag_q;

endmodule
